// File: rtl/wb_lane_buffer_4x32_pkg.sv
// Shared definitions for the four-slot write-back lane buffer and its arbiter.
package wb_lane_buffer_4x32_pkg;

  localparam int NSLOT      = 4;
  localparam int SLOT_IDX_W = 2;
  localparam int W_DEFAULT  = 32;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

  // Number of set bits in a four-bit valid vector, 0..4.
  function automatic logic [2:0] popcount4(input logic [NSLOT-1:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

endpackage

// File: rtl/wb_lane_buffer_4x32_rr_arbiter_4.sv
// Combinational four-way round-robin arbiter: grants the first requester
// found when searching from ptr upward, wrapping modulo 4.
module rr_arbiter_4
  import wb_lane_buffer_4x32_pkg::*;
(
  input  logic [NSLOT-1:0] req,
  input  slot_idx_t        ptr,
  output slot_idx_t        gnt_idx,
  output logic             gnt_vld
);

  slot_idx_t candIdx;

  // Scan from the farthest offset back to ptr so the closest requester wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = |req;
    candIdx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      candIdx = ptr + slot_idx_t'(i);
      if (req[candIdx]) begin
        gnt_idx = candIdx;
      end
    end
  end

endmodule

// File: rtl/wb_lane_buffer_4x32.sv
// Four-slot holding buffer behind the 1-to-4 write-data demux. Each lane
// loads its own slot; buffered words drain one per handshake, round-robin,
// toward the single write-back port.
module wb_lane_buffer_4x32
  import wb_lane_buffer_4x32_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [1:0]      wr_sel,
  input  logic [W-1:0]    lane_d0,
  input  logic [W-1:0]    lane_d1,
  input  logic [W-1:0]    lane_d2,
  input  logic [W-1:0]    lane_d3,
  output logic            wr_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [1:0]      out_slot,
  output logic [2:0]      occupancy
);

  logic [W-1:0]     slot_data_q [NSLOT];
  logic [NSLOT-1:0] slot_vld_q;
  logic [NSLOT-1:0] slot_vld_d;
  slot_idx_t        rr_ptr_q;
  slot_idx_t        rr_ptr_d;
  logic [2:0]       occupancy_q;
  logic [2:0]       occupancy_d;

  slot_idx_t        gnt;
  logic             gntVld;
  logic             drainAcc;
  logic             wrAcc;
  logic [W-1:0]     laneSel;

  rr_arbiter_4 u_arb (
    .req     (slot_vld_q),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt),
    .gnt_vld (gntVld)
  );

  // Pick the data of the lane the demux is currently steering; others are ignored.
  always_comb begin
    laneSel = '0;
    case (wr_sel)
      2'd0:    laneSel = lane_d0;
      2'd1:    laneSel = lane_d1;
      2'd2:    laneSel = lane_d2;
      default: laneSel = lane_d3;
    endcase
  end

  // Handshakes and presentation; a slot being drained this cycle may be refilled.
  always_comb begin
    out_valid = gntVld;
    drainAcc  = gntVld & out_ready;
    wr_ready  = ~slot_vld_q[wr_sel] | (drainAcc & (gnt == wr_sel));
    wrAcc     = wr_en & wr_ready;
    out_data  = gntVld ? slot_data_q[gnt] : '0;
    out_slot  = gntVld ? gnt : '0;
    occupancy = occupancy_q;
  end

  // Next-state valid bits and pointer: the write's set wins over the drain's clear.
  always_comb begin
    slot_vld_d = slot_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (drainAcc) begin
      slot_vld_d[gnt] = 1'b0;
      rr_ptr_d        = gnt + slot_idx_t'(1);
    end
    if (wrAcc) begin
      slot_vld_d[wr_sel] = 1'b1;
    end
    occupancy_d = popcount4(slot_vld_d);
  end

  // State registers with synchronous reset that discards all buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q  <= '0;
      rr_ptr_q    <= '0;
      occupancy_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_data_q[i] <= '0;
      end
    end else begin
      slot_vld_q  <= slot_vld_d;
      rr_ptr_q    <= rr_ptr_d;
      occupancy_q <= occupancy_d;
      if (wrAcc) begin
        slot_data_q[wr_sel] <= laneSel;
      end
    end
  end

endmodule

// File: tb/tb_wb_lane_buffer_4x32.sv
// Directed bench for the four-slot lane buffer with hand-computed expectations.
module tb_wb_lane_buffer_4x32;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [31:0] lane_d0, lane_d1, lane_d2, lane_d3;
  logic        wr_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_slot;
  logic [2:0]  occupancy;

  int checkCount = 0;
  int failCount  = 0;

  wb_lane_buffer_4x32 #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .lane_d0   (lane_d0),
    .lane_d1   (lane_d1),
    .lane_d2   (lane_d2),
    .lane_d3   (lane_d3),
    .wr_ready  (wr_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_slot  (out_slot),
    .occupancy (occupancy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive the write strobe on the selected lane only (others 0, as the demux does).
  task automatic applyStimulus(input logic en, input logic [1:0] sel,
                               input logic [31:0] data, input logic ordy);
    wr_en     = en;
    wr_sel    = sel;
    lane_d0   = (sel == 2'd0) ? data : 32'h0;
    lane_d1   = (sel == 2'd1) ? data : 32'h0;
    lane_d2   = (sel == 2'd2) ? data : 32'h0;
    lane_d3   = (sel == 2'd3) ? data : 32'h0;
    out_ready = ordy;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    doReset();

    // Reset release
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_occupancy", {29'b0, occupancy}, 32'd0);
    checkOutput("rst_wr_ready",  {31'b0, wr_ready},  32'd1);
    checkOutput("rst_out_data",  out_data,           32'h0);
    checkOutput("rst_out_slot",  {30'b0, out_slot},  32'd0);

    // Single path through slot 2
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 1'b0);
    checkOutput("sp_wr_ready", {31'b0, wr_ready}, 32'd1);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("sp_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("sp_out_slot",  {30'b0, out_slot},  32'd2);
    checkOutput("sp_out_data",  out_data,           32'hDEADBEEF);
    checkOutput("sp_occupancy", {29'b0, occupancy}, 32'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("sp_drained_occ",   {29'b0, occupancy}, 32'd0);
    checkOutput("sp_drained_valid", {31'b0, out_valid}, 32'd0);

    // rr_ptr should now be 3: with slots 0 and 3 valid, slot 3 is granted first
    applyStimulus(1'b1, 2'd0, 32'h00000A00, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'd3, 32'h00000A03, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("ptr3_first_slot", {30'b0, out_slot}, 32'd3);
    checkOutput("ptr3_first_data", out_data, 32'h00000A03);
    stepCycle();
    checkOutput("ptr3_wrap_slot", {30'b0, out_slot}, 32'd0);
    checkOutput("ptr3_wrap_data", out_data, 32'h00000A00);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("ptr3_empty", {31'b0, out_valid}, 32'd0);

    // Round-robin drain from a fresh pointer
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'(i), 32'h10 + 32'(i), 1'b0);
      stepCycle();
    end
    applyStimulus(1'b1, 2'd0, 32'hFFFFFFFF, 1'b0);
    checkOutput("rr_full_occ",      {29'b0, occupancy}, 32'd4);
    checkOutput("rr_full_wr_ready", {31'b0, wr_ready},  32'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_slot%0d", i), {30'b0, out_slot}, 32'(i));
      checkOutput($sformatf("rr_data%0d", i), out_data, 32'h10 + 32'(i));
      stepCycle();
    end
    applyStimulus(1'b1, 2'd0, 32'h20, 1'b0);
    checkOutput("rr_empty_occ", {29'b0, occupancy}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("rr_refill_slot", {30'b0, out_slot}, 32'd0);
    checkOutput("rr_refill_data", out_data, 32'h20);
    stepCycle();

    // Full slot: second write to slot 1 is dropped
    applyStimulus(1'b1, 2'd1, 32'hAAAA0001, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'd1, 32'hBBBB0001, 1'b0);
    checkOutput("full_wr_ready", {31'b0, wr_ready}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("full_occ",  {29'b0, occupancy}, 32'd1);
    checkOutput("full_hold", out_data, 32'hAAAA0001);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    checkOutput("full_drain", out_data, 32'hAAAA0001);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("full_empty", {31'b0, out_valid}, 32'd0);

    // Same-slot write and drain on slot 3
    applyStimulus(1'b1, 2'd3, 32'h33, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'd3, 32'h44, 1'b1);
    checkOutput("same_wr_ready", {31'b0, wr_ready}, 32'd1);
    checkOutput("same_old_data", out_data, 32'h33);
    checkOutput("same_old_slot", {30'b0, out_slot}, 32'd3);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("same_new_data", out_data, 32'h44);
    checkOutput("same_occ",      {29'b0, occupancy}, 32'd1);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    stepCycle();

    // Different-slot write and drain (pointer is 0 after draining slot 3)
    applyStimulus(1'b1, 2'd0, 32'h50, 1'b0);
    stepCycle();
    applyStimulus(1'b1, 2'd2, 32'h52, 1'b1);
    checkOutput("diff_drain_slot", {30'b0, out_slot}, 32'd0);
    stepCycle();
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("diff_occ",  {29'b0, occupancy}, 32'd1);
    checkOutput("diff_slot", {30'b0, out_slot},  32'd2);
    checkOutput("diff_data", out_data,           32'h52);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    stepCycle();

    // Reset mid-stream with a write and a drain both requested
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 2'(i), 32'h70 + 32'(i), 1'b0);
      stepCycle();
    end
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    checkOutput("mid_pre_occ", {29'b0, occupancy}, 32'd3);
    rst = 1'b1;
    applyStimulus(1'b1, 2'd3, 32'h99, 1'b1);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 2'd3, 32'h0, 1'b0);
    checkOutput("mid_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid_occ",       {29'b0, occupancy}, 32'd0);
    checkOutput("mid_out_data",  out_data,           32'h0);
    checkOutput("mid_wr_ready",  {31'b0, wr_ready},  32'd1);
    stepCycle();
    checkOutput("mid_no_retain", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
